// File: rtl/gap_state_classifier_if.sv
// Averager/config side to gap classifier bundle: voltage strobe, thresholds, and classifier results.
// master drives samples and config; slave (classifier) returns state, run count, alarm and feed requests.
interface gap_state_classifier_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0] avg_vol;
  logic              avg_valid;
  logic [DATA_W-1:0] short_th;
  logic [DATA_W-1:0] open_th;
  logic              cfg_en;
  logic [1:0]        gap_state;
  logic              state_valid;
  logic [CNT_W-1:0]  short_run;
  logic              short_alarm;
  logic              feed_fwd;
  logic              feed_back;
  logic              cfg_err;

  modport master (
    output avg_vol, avg_valid, short_th, open_th, cfg_en,
    input  gap_state, state_valid, short_run, short_alarm, feed_fwd, feed_back, cfg_err
  );

  modport slave (
    input  avg_vol, avg_valid, short_th, open_th, cfg_en,
    output gap_state, state_valid, short_run, short_alarm, feed_fwd, feed_back, cfg_err
  );
endinterface

// File: rtl/gap_state_classifier.sv
// Classifies each averaged gap voltage as SHORT/NORMAL/OPEN with hysteresis; drives servo feed and short alarm.
// Latency 1 cycle from avg_valid to gap_state/state_valid; no backpressure (strobe in, pulse out).
module gap_state_classifier #(
  parameter int DATA_W    = 16,
  parameter int HYST      = 64,
  parameter int SHORT_CNT = 4,
  parameter int OPEN_CNT  = 8,
  parameter int CNT_W     = 8
) (
  input logic                   clk_100M,
  input logic                   rst_n,
  gap_state_classifier_if.slave bus
);

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'b00,
    ST_SHORT   = 2'b01,
    ST_NORMAL  = 2'b10,
    ST_OPEN    = 2'b11
  } state_t;

  localparam int                 EXT_W     = DATA_W + 1;
  localparam logic [EXT_W-1:0]   V_MAX     = {1'b0, {DATA_W{1'b1}}};
  localparam logic [EXT_W-1:0]   HYST_X    = EXT_W'(HYST);
  localparam logic [CNT_W-1:0]   RUN_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   SHORT_LIM = CNT_W'(SHORT_CNT);
  localparam logic [CNT_W-1:0]   OPEN_LIM  = CNT_W'(OPEN_CNT);

  state_t             state_q, state_d, next_state;
  logic               state_valid_q, state_valid_d;
  logic [CNT_W-1:0]   short_run_q, short_run_d;
  logic [CNT_W-1:0]   open_run_q, open_run_d;
  logic               short_alarm_q, short_alarm_d;
  logic               feed_fwd_q, feed_fwd_d;
  logic               feed_back_q, feed_back_d;
  logic               cfg_err_q, cfg_err_d;

  logic               cfg_bad;
  logic [EXT_W-1:0]   s_hi_sum;
  logic [EXT_W-1:0]   o_lo_diff;
  logic [DATA_W-1:0]  s_hi;
  logic [DATA_W-1:0]  o_lo;
  logic               below_short;
  logic               above_open;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == RUN_MAX) ? c : c + CNT_W'(1);
  endfunction

  assign cfg_bad = (bus.short_th >= bus.open_th);

  // Exit limits use one extra bit so the clamp at the rails is exact.
  assign s_hi_sum  = {1'b0, bus.short_th} + HYST_X;
  assign o_lo_diff = {1'b0, bus.open_th} - HYST_X;
  assign s_hi      = (s_hi_sum > V_MAX) ? V_MAX[DATA_W-1:0] : s_hi_sum[DATA_W-1:0];
  assign o_lo      = o_lo_diff[DATA_W] ? '0 : o_lo_diff[DATA_W-1:0];

  assign below_short = (bus.avg_vol < bus.short_th);
  assign above_open  = (bus.avg_vol > bus.open_th);

  always_comb begin
    next_state = state_q;
    case (state_q)
      ST_UNKNOWN, ST_NORMAL: begin
        if (below_short)     next_state = ST_SHORT;
        else if (above_open) next_state = ST_OPEN;
        else                 next_state = ST_NORMAL;
      end
      ST_SHORT: begin
        if (above_open)             next_state = ST_OPEN;
        else if (bus.avg_vol >= s_hi) next_state = ST_NORMAL;
        else                        next_state = ST_SHORT;
      end
      ST_OPEN: begin
        if (below_short)            next_state = ST_SHORT;
        else if (bus.avg_vol <= o_lo) next_state = ST_NORMAL;
        else                        next_state = ST_OPEN;
      end
      default: next_state = ST_UNKNOWN;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    state_valid_d = 1'b0;
    short_run_d   = short_run_q;
    open_run_d    = open_run_q;
    short_alarm_d = short_alarm_q;
    feed_fwd_d    = feed_fwd_q;
    feed_back_d   = feed_back_q;
    cfg_err_d     = cfg_bad;

    // Disable or bad thresholds win over a coincident sample.
    if (!bus.cfg_en || cfg_bad) begin
      state_d       = ST_UNKNOWN;
      short_run_d   = '0;
      open_run_d    = '0;
      short_alarm_d = 1'b0;
      feed_fwd_d    = 1'b0;
      feed_back_d   = 1'b0;
    end else if (bus.avg_valid) begin
      state_d       = next_state;
      state_valid_d = 1'b1;
      short_run_d   = (next_state == ST_SHORT) ? sat_inc(short_run_q) : '0;
      open_run_d    = (next_state == ST_OPEN)  ? sat_inc(open_run_q)  : '0;
      short_alarm_d = (short_run_d >= SHORT_LIM) && (next_state == ST_SHORT);
      feed_back_d   = (next_state == ST_SHORT);
      feed_fwd_d    = (open_run_d >= OPEN_LIM) && (next_state == ST_OPEN);
    end
  end

  always_ff @(posedge clk_100M) begin
    if (!rst_n) begin
      state_q       <= ST_UNKNOWN;
      state_valid_q <= 1'b0;
      short_run_q   <= '0;
      open_run_q    <= '0;
      short_alarm_q <= 1'b0;
      feed_fwd_q    <= 1'b0;
      feed_back_q   <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      state_valid_q <= state_valid_d;
      short_run_q   <= short_run_d;
      open_run_q    <= open_run_d;
      short_alarm_q <= short_alarm_d;
      feed_fwd_q    <= feed_fwd_d;
      feed_back_q   <= feed_back_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign bus.gap_state   = state_q;
  assign bus.state_valid = state_valid_q;
  assign bus.short_run   = short_run_q;
  assign bus.short_alarm = short_alarm_q;
  assign bus.feed_fwd    = feed_fwd_q;
  assign bus.feed_back   = feed_back_q;
  assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_gap_state_classifier.sv
// Bench for gap_state_classifier: directed scenarios with literal expectations plus
// randomized samples, all checked every cycle against an integer reference model.
module tb_gap_state_classifier;

  localparam int DATA_W    = 16;
  localparam int HYST      = 64;
  localparam int SHORT_CNT = 4;
  localparam int OPEN_CNT  = 8;
  localparam int CNT_W     = 8;
  localparam int VMAX      = (1 << DATA_W) - 1;
  localparam int RMAX      = (1 << CNT_W) - 1;
  localparam int UNK = 0, SH = 1, NO = 2, OP = 3;

  logic clk_100M;
  logic rst_n;

  gap_state_classifier_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus();

  gap_state_classifier #(
    .DATA_W(DATA_W), .HYST(HYST), .SHORT_CNT(SHORT_CNT), .OPEN_CNT(OPEN_CNT), .CNT_W(CNT_W)
  ) dut (
    .clk_100M(clk_100M),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial begin
    clk_100M = 1'b0;
    forever #5 clk_100M = ~clk_100M;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: gap category and run lengths as plain integers.
  int m_state = 0, m_short = 0, m_open = 0;
  bit m_valid = 1'b0, m_cfgerr = 1'b0;

  function automatic int classify(int prev, int v, int sth, int oth);
    int s_hi, o_lo;
    s_hi = sth + HYST;
    if (s_hi > VMAX) s_hi = VMAX;
    o_lo = oth - HYST;
    if (o_lo < 0) o_lo = 0;
    if (prev == SH) begin
      if (v > oth) return OP;
      if (v >= s_hi) return NO;
      return SH;
    end
    if (prev == OP) begin
      if (v < sth) return SH;
      if (v <= o_lo) return NO;
      return OP;
    end
    if (v < sth) return SH;
    if (v > oth) return OP;
    return NO;
  endfunction

  always @(posedge clk_100M) begin
    if (!rst_n) begin
      m_state = UNK; m_short = 0; m_open = 0; m_valid = 0; m_cfgerr = 0;
    end else begin
      m_cfgerr = (int'(bus.short_th) >= int'(bus.open_th));
      m_valid  = 0;
      if (!bus.cfg_en || m_cfgerr) begin
        m_state = UNK; m_short = 0; m_open = 0;
      end else if (bus.avg_valid) begin
        m_state = classify(m_state, int'(bus.avg_vol), int'(bus.short_th), int'(bus.open_th));
        m_short = (m_state == SH) ? ((m_short + 1 > RMAX) ? RMAX : m_short + 1) : 0;
        m_open  = (m_state == OP) ? ((m_open + 1 > RMAX) ? RMAX : m_open + 1) : 0;
        m_valid = 1;
      end
    end
  end

  always @(negedge clk_100M) begin
    if (chk_en) begin
      logic [14:0] act, exp;
      act = {bus.gap_state, bus.state_valid, bus.short_run, bus.short_alarm,
             bus.feed_fwd, bus.feed_back, bus.cfg_err};
      exp = {m_state[1:0], m_valid, m_short[CNT_W-1:0], (m_short >= SHORT_CNT),
             (m_open >= OPEN_CNT), (m_state == SH), m_cfgerr};
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model_cycle t=%0t {state,sv,run,alarm,fwd,back,err} got %h want %h",
                 $time, act, exp);
      end
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100M);
    #1;
  endtask

  task automatic strobe(input int v);
    bus.avg_vol   = v[DATA_W-1:0];
    bus.avg_valid = 1'b1;
    tick();
    bus.avg_valid = 1'b0;
  endtask

  task automatic set_th(input int s, input int o);
    bus.short_th = s[DATA_W-1:0];
    bus.open_th  = o[DATA_W-1:0];
  endtask

  function automatic int clamp(int v);
    if (v < 0) return 0;
    if (v > VMAX) return VMAX;
    return v;
  endfunction

  int th_s[6] = '{1000, 20,    65500, 100, 3000, 500};
  int th_o[6] = '{3000, 40000, 65530, 200, 1000, 500};

  initial begin
    rst_n = 1'b0;
    bus.avg_vol = '0; bus.avg_valid = 1'b0; bus.cfg_en = 1'b1;
    set_th(1000, 3000);
    repeat (3) tick();
    chk_en = 1'b1;
    lit("reset_state", int'(bus.gap_state), 0);
    lit("reset_outputs", int'({bus.state_valid, bus.short_run, bus.short_alarm,
                               bus.feed_fwd, bus.feed_back, bus.cfg_err}), 0);
    rst_n = 1'b1;
    tick();

    strobe(500);
    lit("classify_500", int'(bus.gap_state), 1);
    lit("classify_500_valid", int'(bus.state_valid), 1);
    strobe(2000);
    lit("classify_2000", int'(bus.gap_state), 2);
    strobe(3500);
    lit("classify_3500", int'(bus.gap_state), 3);
    tick();
    lit("valid_one_cycle", int'(bus.state_valid), 0);

    strobe(500);
    strobe(1030);
    lit("hys_short_stay", int'(bus.gap_state), 1);
    lit("model_hys_short_stay", m_state, SH);
    strobe(1064);
    lit("hys_short_leave", int'(bus.gap_state), 2);
    strobe(3500);
    strobe(2950);
    lit("hys_open_stay", int'(bus.gap_state), 3);
    strobe(2936);
    lit("hys_open_leave", int'(bus.gap_state), 2);

    for (int i = 1; i <= 4; i++) begin
      strobe(200);
      lit($sformatf("alarm_after_%0d", i), int'(bus.short_alarm), (i == 4) ? 1 : 0);
    end
    lit("feed_back_short", int'(bus.feed_back), 1);
    strobe(2000);
    lit("alarm_cleared", int'(bus.short_alarm), 0);
    lit("run_cleared", int'(bus.short_run), 0);

    for (int i = 0; i < 300; i++) strobe(100);
    lit("run_saturated", int'(bus.short_run), 255);
    lit("model_run_saturated", m_short, 255);
    for (int i = 1; i <= 8; i++) begin
      strobe(4000);
      lit($sformatf("feed_fwd_after_%0d", i), int'(bus.feed_fwd), (i == 8) ? 1 : 0);
    end
    lit("feed_back_in_open", int'(bus.feed_back), 0);

    set_th(3000, 1000);
    tick();
    lit("cfg_err_set", int'(bus.cfg_err), 1);
    lit("cfg_err_unknown", int'(bus.gap_state), 0);
    lit("cfg_err_feed_clear", int'(bus.feed_fwd), 0);
    strobe(500);
    lit("cfg_err_ignored", int'(bus.state_valid), 0);
    set_th(1000, 3000);
    tick();
    lit("cfg_err_clear", int'(bus.cfg_err), 0);
    strobe(500);
    lit("reenable_short", int'(bus.gap_state), 1);
    bus.cfg_en = 1'b0;
    strobe(3500);
    lit("disable_priority_state", int'(bus.gap_state), 0);
    lit("disable_priority_valid", int'(bus.state_valid), 0);
    bus.cfg_en = 1'b1;
    strobe(3500);
    lit("after_enable_open", int'(bus.gap_state), 3);
    bus.avg_valid = 1'b1;
    rst_n = 1'b0;
    tick();
    bus.avg_valid = 1'b0;
    lit("midrun_reset_state", int'(bus.gap_state), 0);
    lit("midrun_reset_valid", int'(bus.state_valid), 0);
    rst_n = 1'b1;
    tick();

    for (int c = 0; c < 2500; c++) begin
      int mode, s, o, idx;
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 99) < 2) bus.cfg_en = ~bus.cfg_en;
      else if (!bus.cfg_en && $urandom_range(0, 9) == 0) bus.cfg_en = 1'b1;
      if ($urandom_range(0, 149) == 0) begin
        idx = $urandom_range(0, 5);
        set_th(th_s[idx], th_o[idx]);
      end
      s = int'(bus.short_th);
      o = int'(bus.open_th);
      mode = $urandom_range(0, 3);
      case (mode)
        0: bus.avg_vol = DATA_W'($urandom_range(0, VMAX));
        1: bus.avg_vol = DATA_W'(clamp(s + $urandom_range(0, 200) - 100));
        2: bus.avg_vol = DATA_W'(clamp(o + $urandom_range(0, 200) - 100));
        default: bus.avg_vol = DATA_W'(clamp(s + $urandom_range(0, (o > s) ? o - s : 0)));
      endcase
      bus.avg_valid = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.avg_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
